// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined N:1 multiplexer.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Ceiling log2, used to size channel indices; valid for n >= 2.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_cnt.sv
// Auto-scan channel counter: steps 0..N-1 on each advance, cleared in manual mode.
module mux_scan_cnt
    import mux_pkg::*;
#(
    parameter int unsigned N = 64,
    localparam int unsigned SEL_W = clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    output logic [SEL_W-1:0] cnt,
    output logic             last
);

    logic [SEL_W-1:0] cnt_q, cnt_d;

    // Wrap at N-1, not at the natural roll-over of the counter width.
    assign last = (cnt_q == SEL_W'(N - 1));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (adv) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_nx1_pipe.sv
// Registered N:1 multiplexer with valid/ready handshakes, auto-scan and range-error flag.
module mux_nx1_pipe
    import mux_pkg::*;
#(
    parameter int unsigned N = 64,
    parameter int unsigned W = 1,
    localparam int unsigned SEL_W = clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   a,
    input  logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     y,
    output logic [SEL_W-1:0] out_ch,
    output logic             sel_err,
    output logic             scan_wrap
);

    logic             accept;
    logic             scan;
    logic [SEL_W-1:0] cnt;
    logic             cnt_last;
    logic [SEL_W-1:0] ch;
    logic [W-1:0]     y_d;
    logic             err_d;
    logic             wrap_d;

    logic             out_valid_q;
    logic [W-1:0]     y_q;
    logic [SEL_W-1:0] out_ch_q;
    logic             sel_err_q;
    logic             scan_wrap_q;

    assign scan     = (mode == MODE_SCAN);
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    mux_scan_cnt #(
        .N (N)
    ) u_scan_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mode == MODE_MANUAL),
        .adv   (accept && scan),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    // Decoded select: an index with no matching channel yields zero, never X.
    always_comb begin
        ch     = scan ? cnt : sel;
        err_d  = !scan && !(32'(sel) < N);
        wrap_d = scan && cnt_last;
        y_d    = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (ch == SEL_W'(k)) begin
                y_d = a[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            out_ch_q    <= '0;
            sel_err_q   <= 1'b0;
            scan_wrap_q <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                y_q         <= y_d;
                out_ch_q    <= ch;
                sel_err_q   <= err_d;
                scan_wrap_q <= wrap_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign out_ch    = out_ch_q;
    assign sel_err   = sel_err_q;
    assign scan_wrap = scan_wrap_q;

endmodule
